// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter for the 8-bit RX AXI-Stream: holds the 6-byte destination
// address, then replays and passes the frame or discards it, counting both outcomes.
module eth_rx_mac_filter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock125,
  input  logic                   reset,
  input  logic [47:0]            local_mac,
  input  logic                   promisc,
  input  logic                   mcast_en,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [COUNT_WIDTH-1:0] cnt_accept,
  output logic [COUNT_WIDTH-1:0] cnt_drop
);

  typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  hdr [0:5];
  logic [2:0]  idx;
  logic        lat_last, lat_user;
  logic        s_ready, s_beat, m_beat, hdr_done, match;
  logic        inc_accept, inc_drop;
  logic [47:0] dst;

  // The sixth address byte is still on the input bus when the decision is taken.
  assign dst      = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], s_axis_tdata};
  assign match    = promisc | (dst == local_mac) | (&dst) | (mcast_en & hdr[0][0]);
  assign hdr_done = (idx == 3'd5);

  assign s_axis_tready = s_ready & ~reset;
  assign s_beat        = s_axis_tvalid & s_axis_tready;
  assign m_beat        = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_nxt     = state;
    s_ready       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    inc_accept    = 1'b0;
    inc_drop      = 1'b0;
    case (state)
      HDR: begin
        s_ready = 1'b1;
        if (s_axis_tvalid) begin
          if (hdr_done) begin
            if (match) begin
              state_nxt = REPLAY;
            end else begin
              inc_drop  = 1'b1;
              state_nxt = s_axis_tlast ? HDR : DROP;
            end
          end else if (s_axis_tlast) begin
            inc_drop = 1'b1;
          end
        end
      end
      REPLAY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr[idx];
        if (hdr_done) begin
          m_axis_tlast = lat_last;
          m_axis_tuser = lat_user;
          if (m_axis_tready) begin
            inc_accept = lat_last;
            state_nxt  = lat_last ? HDR : PASS;
          end
        end
      end
      PASS: begin
        s_ready       = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          inc_accept = 1'b1;
          state_nxt  = HDR;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) begin
      state      <= HDR;
      idx        <= '0;
      cnt_accept <= '0;
      cnt_drop   <= '0;
    end else begin
      state <= state_nxt;
      if (inc_accept) cnt_accept <= cnt_accept + COUNT_WIDTH'(1);
      if (inc_drop)   cnt_drop   <= cnt_drop + COUNT_WIDTH'(1);
      // idx indexes header capture in HDR and header replay in REPLAY.
      if (state == HDR && s_beat)
        idx <= (hdr_done || s_axis_tlast) ? 3'd0 : idx + 3'd1;
      else if (state == REPLAY && m_beat)
        idx <= hdr_done ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clock125) begin
    if (state == HDR && s_beat) begin
      hdr[idx] <= s_axis_tdata;
      if (hdr_done) begin
        lat_last <= s_axis_tlast;
        lat_user <= s_axis_tuser;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed and randomized-handshake bench for eth_rx_mac_filter with a frame-level reference model.
module tb_eth_rx_mac_filter;
  localparam int CW = 32;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  logic          clock125 = 1'b0;
  logic          reset = 1'b1;
  logic [47:0]   local_mac = LOCAL;
  logic          promisc = 1'b0, mcast_en = 1'b0;
  logic [7:0]    s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready = 1'b1;
  logic [CW-1:0] cnt_accept, cnt_drop;

  int checks = 0, errors = 0;
  int exp_acc = 0, exp_drop = 0;
  bit rand_ready = 0, rand_valid = 0;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  logic [7:0] frame[$];
  bit         prev_stall = 0;
  logic [9:0] prev_beat = '0;

  eth_rx_mac_filter #(.COUNT_WIDTH(CW)) dut (
    .clock125(clock125), .reset(reset), .local_mac(local_mac),
    .promisc(promisc), .mcast_en(mcast_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cnt_accept(cnt_accept), .cnt_drop(cnt_drop)
  );

  always #4 clock125 = ~clock125;

  always @(posedge clock125) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: records taken beats and checks that a stalled beat is held.
  always @(negedge clock125) begin
    if (!reset && prev_stall) begin
      checks++;
      if (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_beat) begin
        errors++;
        $display("FAIL hold: valid=%b beat=%h, required valid=1 beat=%h", m_axis_tvalid,
                 {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_beat);
      end
    end
    if (!reset && m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    prev_stall = !reset && m_axis_tvalid && !m_axis_tready;
    prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
  end

  task automatic apply_reset();
    @(posedge clock125); #1;
    reset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (2) @(posedge clock125);
    #1;
    reset = 1'b0;
    got.delete(); exp_q.delete();
    exp_acc = 0; exp_drop = 0;
  endtask

  task automatic make_frame(input logic [47:0] dst, input int len, input logic [7:0] seed);
    frame.delete();
    for (int i = 0; i < len; i++) frame.push_back(i < 6 ? dst[47-8*i -: 8] : seed + 8'(i));
  endtask

  task automatic model(input logic user);
    logic [47:0] d;
    bit hit;
    if (frame.size() < 6) begin exp_drop++; return; end
    d = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
    hit = promisc || (d == local_mac) || (d == BCAST) || (mcast_en && frame[0][0]);
    if (!hit) begin exp_drop++; return; end
    exp_acc++;
    for (int i = 0; i < frame.size(); i++)
      exp_q.push_back({user && (i == frame.size() - 1), i == frame.size() - 1, frame[i]});
  endtask

  task automatic send_frame(input logic user, input bit with_last);
    int w;
    for (int i = 0; i < frame.size(); i++) begin
      if (rand_valid)
        while ($urandom_range(0, 1) == 0) begin s_axis_tvalid = 1'b0; @(posedge clock125); #1; end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frame[i];
      s_axis_tlast  = with_last && (i == frame.size() - 1);
      s_axis_tuser  = s_axis_tlast & user;
      w = 0;
      @(negedge clock125);
      while (!s_axis_tready && w < 300) begin w++; @(negedge clock125); end
      if (!s_axis_tready) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d tready=0 after %0d cycles, required 1", i, w);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clock125); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (got.size() < exp_q.size() && n < limit) begin @(posedge clock125); n++; end
    repeat (10) @(posedge clock125);
    #1;
  endtask

  function automatic int first_diff();
    int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    return (got.size() == exp_q.size()) ? -1 : n;
  endfunction

  task automatic test_reset();
    s_axis_tvalid = 1'b1;
    @(negedge clock125);
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, required 0", s_axis_tready); end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
      errors++; $display("FAIL rst_mout: got v=%b l=%b u=%b d=%h, required all 0",
                         m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    checks++;
    if (cnt_accept !== 32'd0 || cnt_drop !== 32'd0) begin
      errors++; $display("FAIL rst_cnt: got acc=%0d drop=%0d, required 0/0", cnt_accept, cnt_drop);
    end
    @(posedge clock125); #1;
    s_axis_tvalid = 1'b0;
    @(posedge clock125); #1;
    reset = 1'b0;
    @(negedge clock125);
    checks++;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL hdr_tready: got %b, required 1", s_axis_tready); end
    @(posedge clock125); #1;
  endtask

  task automatic test_unicast();
    int d;
    apply_reset();
    make_frame(LOCAL, 64, 8'h40);
    model(1'b0);
    send_frame(1'b0, 1'b1);
    drain(500);
    checks++;
    if (got.size() != 64 || got[63][8] !== 1'b1 || got[62][8] !== 1'b0) begin
      errors++; $display("FAIL uni_len: got %0d beats, required 64 with tlast only on the last", got.size());
    end
    checks++; d = first_diff();
    if (d >= 0) begin errors++; $display("FAIL uni_stream: beat %0d got %h, required %h", d,
                d < got.size() ? got[d] : 10'h3ff, d < exp_q.size() ? exp_q[d] : 10'h3ff); end
    checks++;
    if (cnt_accept !== 32'd1 || cnt_drop !== 32'd0) begin
      errors++; $display("FAIL uni_cnt: got acc=%0d drop=%0d, required 1/0", cnt_accept, cnt_drop);
    end
  endtask

  task automatic test_promisc();
    int d;
    apply_reset();
    make_frame(OTHER, 30, 8'h10);
    send_frame(1'b0, 1'b1);
    make_frame(OTHER, 6, 8'h00);
    send_frame(1'b0, 1'b1);
    drain(200);
    checks++;
    if (got.size() != 0 || cnt_drop !== 32'd2 || cnt_accept !== 32'd0) begin
      errors++; $display("FAIL miss: got beats=%0d acc=%0d drop=%0d, required 0/0/2", got.size(), cnt_accept, cnt_drop);
    end
    promisc = 1'b1;
    make_frame(OTHER, 20, 8'h20);
    model(1'b0);
    send_frame(1'b0, 1'b1);
    promisc = 1'b0;
    drain(200);
    checks++; d = first_diff();
    if (d >= 0) begin errors++; $display("FAIL promisc_stream: beat %0d got %h, required %h", d,
                d < got.size() ? got[d] : 10'h3ff, d < exp_q.size() ? exp_q[d] : 10'h3ff); end
    checks++;
    if (cnt_accept !== 32'd1 || cnt_drop !== 32'd2) begin
      errors++; $display("FAIL promisc_cnt: got acc=%0d drop=%0d, required 1/2", cnt_accept, cnt_drop);
    end
  endtask

  task automatic test_group();
    int d;
    apply_reset();
    mcast_en = 1'b0;
    make_frame(BCAST, 12, 8'h30); model(1'b0); send_frame(1'b0, 1'b1);
    make_frame(MCAST, 12, 8'h50); model(1'b0); send_frame(1'b0, 1'b1);
    mcast_en = 1'b1;
    make_frame(MCAST, 9, 8'h70);  model(1'b0); send_frame(1'b0, 1'b1);
    mcast_en = 1'b0;
    drain(300);
    checks++;
    if (got.size() != 21) begin errors++; $display("FAIL group_len: got %0d beats, required 21", got.size()); end
    checks++; d = first_diff();
    if (d >= 0) begin errors++; $display("FAIL group_stream: beat %0d got %h, required %h", d,
                d < got.size() ? got[d] : 10'h3ff, d < exp_q.size() ? exp_q[d] : 10'h3ff); end
    checks++;
    if (cnt_accept !== 32'd2 || cnt_drop !== 32'd1) begin
      errors++; $display("FAIL group_cnt: got acc=%0d drop=%0d, required 2/1", cnt_accept, cnt_drop);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    apply_reset();
    make_frame(LOCAL, 4, 8'h00);  model(1'b0); send_frame(1'b0, 1'b1);
    make_frame(LOCAL, 15, 8'hA0); model(1'b0); send_frame(1'b0, 1'b1);
    drain(200);
    checks++; d = first_diff();
    if (d >= 0) begin errors++; $display("FAIL b2b_stream: beat %0d got %h, required %h", d,
                d < got.size() ? got[d] : 10'h3ff, d < exp_q.size() ? exp_q[d] : 10'h3ff); end
    checks++;
    if (cnt_accept !== 32'd1 || cnt_drop !== 32'd1) begin
      errors++; $display("FAIL b2b_cnt: got acc=%0d drop=%0d, required 1/1", cnt_accept, cnt_drop);
    end
  endtask

  task automatic test_random();
    int d, len, kind;
    logic [47:0] dst;
    logic user;
    apply_reset();
    rand_ready = 1; rand_valid = 1;
    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: dst = LOCAL;
        1: dst = OTHER;
        2: dst = BCAST;
        3: dst = MCAST;
        default: dst = LOCAL ^ 48'h0100_0000_0000;
      endcase
      len = $urandom_range(1, 24);
      user = 1'($urandom_range(0, 1));
      promisc = ($urandom_range(0, 3) == 0);
      mcast_en = 1'($urandom_range(0, 1));
      make_frame(dst, len, 8'(f));
      model(user);
      send_frame(user, 1'b1);
    end
    promisc = 1'b0; mcast_en = 1'b0;
    drain(5000);
    rand_ready = 0; rand_valid = 0;
    checks++; d = first_diff();
    if (d >= 0) begin errors++; $display("FAIL rand_stream: beat %0d got %h (n=%0d), required %h (n=%0d)", d,
                d < got.size() ? got[d] : 10'h3ff, got.size(), d < exp_q.size() ? exp_q[d] : 10'h3ff, exp_q.size()); end
    checks++;
    if (cnt_accept !== 32'(exp_acc) || cnt_drop !== 32'(exp_drop)) begin
      errors++; $display("FAIL rand_cnt: got acc=%0d drop=%0d, required %0d/%0d", cnt_accept, cnt_drop, exp_acc, exp_drop);
    end
  endtask

  task automatic test_tuser_reset();
    int d;
    apply_reset();
    make_frame(LOCAL, 6, 8'h00); model(1'b1); send_frame(1'b1, 1'b1);
    drain(100);
    checks++;
    if (got.size() != 6 || got[5] !== {2'b11, LOCAL[7:0]} || got[4][9:8] !== 2'b00) begin
      errors++; $display("FAIL short_user: got %0d beats last=%h, required 6 beats last=%h",
                         got.size(), got.size() == 6 ? got[5] : 10'h3ff, {2'b11, LOCAL[7:0]});
    end
    checks++;
    if (cnt_accept !== 32'd1) begin errors++; $display("FAIL short_cnt: got %0d, required 1", cnt_accept); end
    make_frame(LOCAL, 10, 8'h80);
    send_frame(1'b0, 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55;
    @(negedge clock125);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h55) begin
      errors++; $display("FAIL pass_thru: got v=%b d=%h, required v=1 d=55", m_axis_tvalid, m_axis_tdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || s_axis_tready !== 1'b0 || cnt_accept !== 32'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%h rdy=%b acc=%0d, required 0/00/0/0",
                         m_axis_tvalid, m_axis_tdata, s_axis_tready, cnt_accept);
    end
    @(posedge clock125); #1;
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    got.delete(); exp_q.delete();
    make_frame(LOCAL, 8, 8'hC0); model(1'b0); send_frame(1'b0, 1'b1);
    drain(100);
    checks++; d = first_diff();
    if (d >= 0) begin errors++; $display("FAIL post_reset_stream: beat %0d got %h, required %h", d,
                d < got.size() ? got[d] : 10'h3ff, d < exp_q.size() ? exp_q[d] : 10'h3ff); end
    checks++;
    if (cnt_accept !== 32'd1 || cnt_drop !== 32'd0) begin
      errors++; $display("FAIL post_reset_cnt: got acc=%0d drop=%0d, required 1/0", cnt_accept, cnt_drop);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_promisc();
    test_group();
    test_back_to_back();
    test_random();
    test_tuser_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
